// File: rtl/seq_frame_tx.sv
// Serial frame transmitter for the 1101 sync-pattern link.
// Emits sync word 1101, then the payload MSB-first. A 0 is stuffed after every 110 in the payload,
// so 1101 can only appear as the sync word. A gap of zeros follows each frame.
module seq_frame_tx #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              dout,
    output logic              dout_valid,
    output logic              dout_stuff,
    output logic              frame_done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned GAP_W = $clog2(IDLE_GAP + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IDLE_GAP);
    localparam logic [3:0]       SYNC_WORD = 4'b1101;

    typedef enum logic [1:0] {StIdle, StSync, StData, StGap} state_e;
    // Mirror of the receiver's overlapping 1101 detector state.
    typedef enum logic [1:0] {TrkInit, TrkOne, TrkOneOne, TrkOneOneZero} trk_e;

    state_e             state;
    trk_e               trk;
    logic [DATA_W-1:0]  shreg;
    logic [1:0]         sync_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               sync_bit;

    // Detector transition; a 1 in state 110 is a hit and overlaps into state 1.
    function automatic trk_e trk_next(input trk_e s, input logic b);
        trk_e n;
        n = TrkInit;
        unique case (s)
            TrkInit:       n = b ? TrkOne    : TrkInit;
            TrkOne:        n = b ? TrkOneOne : TrkInit;
            TrkOneOne:     n = b ? TrkOneOne : TrkOneOneZero;
            TrkOneOneZero: n = b ? TrkOne    : TrkInit;
        endcase
        return n;
    endfunction

    // sync_cnt counts bits already sent, so 3 - sync_cnt selects the next sync bit MSB-first.
    assign sync_bit = SYNC_WORD[~sync_cnt];
    assign in_ready = (state == StIdle);

    // Frame sequencing with registered serial outputs and tracker update on every emitted bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            trk        <= TrkInit;
            shreg      <= '0;
            sync_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_stuff <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout_stuff <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        shreg      <= in_data;
                        dout       <= SYNC_WORD[3];
                        dout_valid <= 1'b1;
                        trk        <= trk_next(trk, SYNC_WORD[3]);
                        sync_cnt   <= 2'd1;
                        state      <= StSync;
                    end else begin
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        trk        <= trk_next(trk, 1'b0);
                    end
                end
                StSync: begin
                    dout     <= sync_bit;
                    trk      <= trk_next(trk, sync_bit);
                    sync_cnt <= sync_cnt + 2'd1;
                    if (sync_cnt == 2'd3) begin
                        bit_cnt <= '0;
                        state   <= StData;
                    end
                end
                StData: begin
                    if (trk == TrkOneOneZero) begin
                        // Stuffed zero: payload holds its position, detector falls back to init.
                        dout       <= 1'b0;
                        dout_stuff <= 1'b1;
                        trk        <= TrkInit;
                    end else begin
                        dout    <= shreg[DATA_W-1];
                        trk     <= trk_next(trk, shreg[DATA_W-1]);
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            frame_done <= 1'b1;
                            gap_cnt    <= '0;
                            state      <= StGap;
                        end
                    end
                end
                StGap: begin
                    // Entered while the last payload bit is on dout, so it lasts IDLE_GAP + 1 cycles.
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    trk        <= trk_next(trk, 1'b0);
                    if (gap_cnt == GAP_LAST) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx plus a random loopback through a reference 1101 detector
// and destuffing receiver.
module tb_seq_frame_tx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          dout;
    logic          dout_valid;
    logic          dout_stuff;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    // Loopback monitor state.
    bit            mon_en = 1'b0;
    int            det = 0;
    int            vpos = 0;
    int            hits = 0;
    int            bad_hits = 0;
    int            rcnt = 0;
    logic [DW-1:0] rword = '0;
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] txq[$];

    seq_frame_tx #(.DATA_W(DW), .IDLE_GAP(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_stuff (dout_stuff),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int det_next(input int s, input logic b);
        case (s)
            0:       return b ? 1 : 0;
            1:       return b ? 2 : 0;
            2:       return b ? 2 : 3;
            default: return b ? 1 : 0;
        endcase
    endfunction

    // Reference detector and destuffing receiver watching the serial line.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (dout_valid) vpos = vpos + 1;
            else begin
                vpos = 0;
                rcnt = 0;
            end
            if (det == 3 && dout) begin
                hits = hits + 1;
                if (vpos != 4) bad_hits = bad_hits + 1;
            end
            if (dout_valid && vpos > 4 && !(det == 3 && !dout)) begin
                rword = {rword[DW-2:0], dout};
                rcnt  = rcnt + 1;
                if (rcnt == DW) begin
                    rxq.push_back(rword);
                    rcnt = 0;
                end
            end
            det = det_next(det, dout);
        end
    end

    // Sends one word from IDLE and checks the whole frame, the gap and the following IDLE cycle.
    task automatic frame(input logic [DW-1:0] data, input logic [DW-1:0] next_data, input bit hold,
                         input logic [31:0] exp_bits, input int len, input logic [31:0] exp_stuff,
                         input string tag);
        logic [31:0] bits, stuff, valid, fd;
        logic        rdy_seen, gap_bad;
        bits = '0; stuff = '0; valid = '0; fd = '0;
        rdy_seen = 1'b0; gap_bad = 1'b0;
        check({tag, "_rdy_pre"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        step();
        in_data = next_data;
        if (!hold) in_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            bits  = {bits[30:0], dout};
            stuff = {stuff[30:0], dout_stuff};
            valid = {valid[30:0], dout_valid};
            fd    = {fd[30:0], frame_done};
            rdy_seen |= in_ready;
            step();
        end
        for (int g = 0; g < 2; g++) begin
            gap_bad |= dout | dout_valid | in_ready | frame_done;
            step();
        end
        check({tag, "_bits"}, bits, exp_bits);
        check({tag, "_stuff"}, stuff, exp_stuff);
        check({tag, "_valid"}, valid, (32'd1 << len) - 32'd1);
        check({tag, "_done"}, fd, 32'd1);
        check({tag, "_rdy_busy"}, {31'd0, rdy_seen}, 32'd0);
        check({tag, "_gap"}, {31'd0, gap_bad}, 32'd0);
        check({tag, "_idle"}, {29'd0, in_ready, dout, dout_valid}, 32'b100);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("t5_rdy", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
        txq.push_back(w);
    endtask

    initial begin
        logic fd_seen, v_seen;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        step();
        step();
        check("rst_out", {28'd0, dout, dout_valid, dout_stuff, frame_done}, 32'd0);
        check("rst_rdy", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        step();

        // T1/T2: plain and stuffed frames; in_data changes after accept must be ignored.
        frame(8'h00, 8'hFF, 1'b0, 32'hD00, 12, 32'h0, "t1");
        frame(8'hDB, 8'h00, 1'b0, 32'h3733, 14, 32'h44, "t2");

        // T3: in_valid held across two frames, exactly one IDLE cycle between them.
        frame(8'hFF, 8'h6D, 1'b1, 32'hDFF, 12, 32'h0, "t3a");
        frame(8'h6D, 8'hA5, 1'b0, 32'h3599, 14, 32'h22, "t3b");

        // T4: reset during the 3rd payload bit aborts the frame.
        in_valid = 1'b1;
        in_data  = 8'h00;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("t4_inflight", {31'd0, dout_valid}, 32'd1);
        rst = 1'b1;
        step();
        check("t4_abort", {29'd0, dout, dout_valid, frame_done}, 32'd0);
        check("t4_rdy", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        step();
        check("t4_rst_prio", {30'd0, dout_valid, in_ready}, 32'b01);
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        check("t4_rdy_after", {31'd0, in_ready}, 32'd1);
        fd_seen = 1'b0;
        v_seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            fd_seen |= frame_done;
            v_seen  |= dout_valid;
            step();
        end
        check("t4_no_done", {30'd0, fd_seen, v_seen}, 32'd0);

        // T5/T6: random loopback through the reference detector and receiver.
        mon_en = 1'b1;
        for (int i = 0; i < 1000; i++) send_word(DW'($urandom));
        for (int i = 0; i < 40; i++) step();
        mon_en = 1'b0;
        check("t5_hits", hits, 1000);
        check("t5_bad_hits", bad_hits, 0);
        check("t6_count", rxq.size(), 1000);
        for (int i = 0; i < 1000 && i < rxq.size(); i++) begin
            check("t6_word", {24'd0, rxq[i]}, {24'd0, txq[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
